reaction_round_scorer: RTL and testbench
========================================

// Module: reaction_round_scorer
// PURPOSE
//  Parametrised multi-round hit/miss scorer for the switch-vs-LED reaction game.
//  Per round: requests a one-hot target from the randomizer, arms a timeout window,
//  and classifies the next switch flip as hit, wrong-switch miss, or timeout miss.
//  Keeps score/miss/round counters and a free-running token that seeds the randomizer.
//  Sits between the switch inputs, the randomizer and the score display.
// PARAMETERS
//  N_SW      8   switch/LED/token width
//  TMO_W     16  width of timeout_cycles and internal timer
//  SCORE_W   8   width of score and misses (both saturate at 2**SCORE_W-1)
//  ROUNDS    16  rounds per game (>=1); round_cnt is $clog2(ROUNDS+1) bits wide
// PORTS
//  clk            in   1        clock
//  rst            in   1        reset, asynchronous, active-high
//  start          in   1        pulse: begin new game (honoured in IDLE/DONE only)
//  switch         in   N_SW     raw switch levels (already synchronised upstream)
//  target         in   N_SW     one-hot LED target from randomizer
//  target_valid   in   1        target is valid
//  target_req     out  1        request a target; captured when target_req&&target_valid
//  timeout_cycles in   TMO_W    round window in cycles; 0 treated as 1
//  led            out  N_SW     captured target, shown only while ARMED, else 0
//  token          out  N_SW     token counter seed for randomizer
//  hit            out  1        1-cycle pulse: correct switch flipped
//  miss           out  1        1-cycle pulse: wrong flip or timeout
//  score          out  SCORE_W  hits this game
//  misses         out  SCORE_W  misses this game
//  round_cnt      out  $clog2(ROUNDS+1)  rounds resolved this game
//  busy           out  1        state in REQ or ARMED
//  done           out  1        high in DONE until next start
// BEHAVIOUR
//  Reset: all outputs/registers 0, switch_mem=0, state IDLE.
//  Flip detect: every cycle changed=switch^switch_mem; switch_mem<=switch whenever
//   they differ, in every state (flips outside ARMED are absorbed, never scored).
//  FSM: IDLE -start-> REQ (clear score/misses/round_cnt).
//   REQ: target_req=1; on valid with popcount(target)==1 capture target, timer=0 -> ARMED.
//   Non-one-hot target is discarded; stay in REQ, target_req held high.
//   ARMED: flip (changed!=0) -> changed==target ? hit : miss; else timer==max(tmo,1)-1
//   -> miss (timeout); else timer++. On resolution round_cnt++, then
//   round_cnt+1==ROUNDS -> DONE, else -> REQ.  DONE: done=1; start -> REQ (clears).
//  Simultaneous flip and timeout in same cycle: flip classification wins.
//  Multi-bit flip containing the target bit is a miss (exact match required).
//  Latency: flip first sampled at edge k -> hit/miss high cycle after k, counters
//   updated at edge k; next target_req asserted from same cycle.
//  start while busy ignored. timeout_cycles sampled each cycle (change mid-round legal).
//  Counters: score/misses saturate, never wrap. token: +1 per cycle, wraps mod 2**N_SW,
//   cleared to 0 on the edge a hit is registered.
//  Reset mid-round: immediate return to IDLE, pulses and counters cleared.
// STRUCTURE
//  Package game_pkg: state enum (IDLE,REQ,ARMED,DONE), function is_onehot(N_SW).
//  Sub-module flip_detect (switch_mem register, changed vector, any_flip flag).
//  Timer, counters and FSM in this module.
// TESTING
//  1 Reset, start, target=8'h04 valid, flip bit2 -> hit=1 one cycle, score=1, led=0.
//  2 ARMED target 8'h04, flip bit5 -> miss=1, misses=1, score unchanged, token not cleared.
//  3 timeout_cycles=10, no flips -> miss 10 cycles after ARMED entry; =0 -> miss after 1.
//  4 Flip target on exact timeout cycle -> hit, no miss; flip bits2+3 -> miss.
//  5 target=8'h06 then 8'h00 -> stays REQ, target_req=1; then 8'h01 -> ARMED.
//  6 ROUNDS=4: 4 resolutions -> done=1, busy=0; start -> counters 0; rst mid-ARMED -> IDLE.

Source files
------------

// File: rtl/game_pkg.sv
// Shared types and helpers for the reaction-game scorer.
package game_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      REQ   = 2'd1,
      ARMED = 2'd2,
      DONE  = 2'd3
   } state_e;

   localparam int ONEHOT_MAX_W = 64;

   // Callers zero-extend their vector to ONEHOT_MAX_W; extra zeros do not change the count.
   function automatic logic is_onehot(input logic [ONEHOT_MAX_W-1:0] v);
      return $countones(v) == 1;
   endfunction

endpackage

// File: rtl/reaction_round_scorer_if.sv
// Game-side bus of the round scorer: start/switch/randomizer handshake in, score display out.
interface reaction_round_scorer_if #(
   parameter int N_SW    = 8,
   parameter int TMO_W   = 16,
   parameter int SCORE_W = 8,
   parameter int ROUNDS  = 16
);
   localparam int RC_W = $clog2(ROUNDS + 1);

   logic               start;
   logic [N_SW-1:0]    switch;
   logic [N_SW-1:0]    target;
   logic               target_valid;
   logic               target_req;
   logic [TMO_W-1:0]   timeout_cycles;
   logic [N_SW-1:0]    led;
   logic [N_SW-1:0]    token;
   logic               hit;
   logic               miss;
   logic [SCORE_W-1:0] score;
   logic [SCORE_W-1:0] misses;
   logic [RC_W-1:0]    round_cnt;
   logic               busy;
   logic               done;

   modport master (
      output start, switch, target, target_valid, timeout_cycles,
      input  target_req, led, token, hit, miss, score, misses, round_cnt, busy, done
   );

   modport slave (
      input  start, switch, target, target_valid, timeout_cycles,
      output target_req, led, token, hit, miss, score, misses, round_cnt, busy, done
   );

endinterface

// File: rtl/reaction_round_scorer_flip_detect.sv
// Remembers the last switch levels and flags any bit that changed since the previous cycle.
module flip_detect #(
   parameter int N_SW = 8
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [N_SW-1:0] switch_i,
   output logic [N_SW-1:0] changed,
   output logic            any_flip
);

   logic [N_SW-1:0] switch_mem_q, switch_mem_d;

   // Tracking every cycle absorbs flips made outside the scoring window.
   always_comb begin
      changed      = switch_i ^ switch_mem_q;
      any_flip     = |changed;
      switch_mem_d = switch_i;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) switch_mem_q <= '0;
      else     switch_mem_q <= switch_mem_d;
   end

endmodule

// File: rtl/reaction_round_scorer.sv
// Multi-round reaction game scorer: fetches a one-hot target, times the round window and
// classifies the next switch flip as hit, wrong-switch miss or timeout miss.
module reaction_round_scorer
   import game_pkg::*;
#(
   parameter int N_SW    = 8,
   parameter int TMO_W   = 16,
   parameter int SCORE_W = 8,
   parameter int ROUNDS  = 16
) (
   input logic                    clk,
   input logic                    rst,
   reaction_round_scorer_if.slave bus
);

   localparam int RC_W = $clog2(ROUNDS + 1);

   state_e             state_q, state_d;
   logic [N_SW-1:0]    target_q, target_d;
   logic [TMO_W-1:0]   timer_q, timer_d;
   logic [SCORE_W-1:0] score_q, score_d;
   logic [SCORE_W-1:0] misses_q, misses_d;
   logic [RC_W-1:0]    round_q, round_d;
   logic [N_SW-1:0]    token_q, token_d;
   logic               hit_q, hit_d;
   logic               miss_q, miss_d;

   logic [N_SW-1:0]    changed;
   logic               any_flip;
   logic               armed, start_ok, tgt_ok;
   logic               flip_res, is_hit, timeout, resolve, last_round;
   logic [TMO_W-1:0]   tmo_last;
   logic [RC_W-1:0]    round_inc;

   flip_detect #(.N_SW(N_SW)) u_flip (
      .clk      (clk),
      .rst      (rst),
      .switch_i (bus.switch),
      .changed  (changed),
      .any_flip (any_flip)
   );

   // Round resolution; a flip outranks a timeout landing on the same edge.
   always_comb begin
      armed      = state_q == ARMED;
      start_ok   = (state_q == IDLE || state_q == DONE) && bus.start;
      tgt_ok     = state_q == REQ && bus.target_valid && is_onehot(ONEHOT_MAX_W'(bus.target));
      tmo_last   = (bus.timeout_cycles == '0) ? '0 : bus.timeout_cycles - TMO_W'(1);
      flip_res   = armed && any_flip;
      is_hit     = flip_res && changed == target_q;
      // >= so a window shortened mid-round below the elapsed time expires immediately.
      timeout    = armed && !any_flip && timer_q >= tmo_last;
      resolve    = flip_res || timeout;
      round_inc  = round_q + RC_W'(1);
      last_round = round_inc == RC_W'(ROUNDS);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE, DONE: if (start_ok) state_d = REQ;
         REQ:        if (tgt_ok)   state_d = ARMED;
         ARMED:      if (resolve)  state_d = last_round ? DONE : REQ;
         default:                  state_d = IDLE;
      endcase
   end

   always_comb begin
      target_d = target_q;
      timer_d  = timer_q;
      score_d  = score_q;
      misses_d = misses_q;
      round_d  = round_q;
      token_d  = token_q + N_SW'(1);
      hit_d    = is_hit;
      miss_d   = resolve && !is_hit;
      if (start_ok) begin
         score_d  = '0;
         misses_d = '0;
         round_d  = '0;
      end
      if (tgt_ok) begin
         target_d = bus.target;
         timer_d  = '0;
      end
      if (armed && !resolve) timer_d = timer_q + TMO_W'(1);
      if (resolve) begin
         round_d = round_inc;
         if (is_hit) begin
            if (score_q != '1) score_d = score_q + SCORE_W'(1);
         end else if (misses_q != '1) begin
            misses_d = misses_q + SCORE_W'(1);
         end
      end
      if (is_hit) token_d = '0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         target_q <= '0;
         timer_q  <= '0;
         score_q  <= '0;
         misses_q <= '0;
         round_q  <= '0;
         token_q  <= '0;
         hit_q    <= 1'b0;
         miss_q   <= 1'b0;
      end else begin
         target_q <= target_d;
         timer_q  <= timer_d;
         score_q  <= score_d;
         misses_q <= misses_d;
         round_q  <= round_d;
         token_q  <= token_d;
         hit_q    <= hit_d;
         miss_q   <= miss_d;
      end
   end

   always_comb begin
      bus.target_req = state_q == REQ;
      bus.led        = (state_q == ARMED) ? target_q : '0;
      bus.busy       = state_q == REQ || state_q == ARMED;
      bus.done       = state_q == DONE;
   end

   assign bus.hit       = hit_q;
   assign bus.miss      = miss_q;
   assign bus.score     = score_q;
   assign bus.misses    = misses_q;
   assign bus.round_cnt = round_q;
   assign bus.token     = token_q;

endmodule

// File: tb/tb_reaction_round_scorer.sv
// Randomized round-level bench for reaction_round_scorer against a game-rule reference model.
module tb_reaction_round_scorer;

   localparam int N_SW    = 8;
   localparam int TMO_W   = 16;
   localparam int SCORE_W = 2;
   localparam int ROUNDS  = 4;
   localparam int SMAX    = (1 << SCORE_W) - 1;

   logic clk = 1'b0;
   logic rst = 1'b1;

   reaction_round_scorer_if #(.N_SW(N_SW), .TMO_W(TMO_W), .SCORE_W(SCORE_W), .ROUNDS(ROUNDS)) bus ();

   reaction_round_scorer #(.N_SW(N_SW), .TMO_W(TMO_W), .SCORE_W(SCORE_W), .ROUNDS(ROUNDS)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_fail = 0;
   int cyc = 0;
   int exp_score, exp_miss, exp_round, tok_base;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Token counts edges since reset release or since the last registered hit.
   function automatic int tok_exp();
      return (cyc - tok_base) & ((1 << N_SW) - 1);
   endfunction

   task automatic chk_counters(input string tag);
      chk({tag, "_score"},  32'(bus.score),     exp_score);
      chk({tag, "_misses"}, 32'(bus.misses),    exp_miss);
      chk({tag, "_round"},  32'(bus.round_cnt), exp_round);
      chk({tag, "_token"},  32'(bus.token),     tok_exp());
   endtask

   task automatic start_game();
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      exp_score = 0;
      exp_miss  = 0;
      exp_round = 0;
      chk("start_busy", 32'(bus.busy), 1);
      chk("start_done", 32'(bus.done), 0);
      chk_counters("start");
   endtask

   task automatic end_game();
      tick();
      chk("end_done", 32'(bus.done), 1);
      chk("end_busy", 32'(bus.busy), 0);
      chk("end_req",  32'(bus.target_req), 0);
      chk("end_pulse", 32'({bus.hit, bus.miss}), 0);
      chk_counters("end");
   endtask

   // kind: 0 hit, 1 wrong single switch, 2 target plus another switch, 3 timeout.
   task automatic do_round(input int idx, input int kind, input int d, input int tmo,
                           input logic [7:0] bad, input bit sb);
      logic [7:0] tgt, mask;
      int teff, dd, j;
      bit got_hit;
      tgt = '0;
      tgt[idx] = 1'b1;
      teff = (tmo == 0) ? 1 : tmo;
      dd   = (d > teff - 1) ? teff - 1 : d;
      j    = (idx + 1 + int'($urandom_range(0, 6))) % 8;
      bus.timeout_cycles = TMO_W'(tmo);
      chk("req_on", 32'(bus.target_req), 1);
      bus.switch[$urandom_range(0, 7)] ^= 1'b1;
      bus.start = sb;
      tick();
      bus.start = 1'b0;
      chk("req_pulse_lo", 32'({bus.hit, bus.miss}), 0);
      chk("req_led", 32'(bus.led), 0);
      chk("req_hold", 32'(bus.target_req), 1);
      chk_counters("req");
      if (bad != 0) begin
         bus.target_valid = 1'b1;
         bus.target = bad;
         tick();
         chk("bad_req", 32'(bus.target_req), 1);
         chk("bad_led", 32'(bus.led), 0);
         bus.target = 8'h00;
         tick();
         chk("zero_req", 32'(bus.target_req), 1);
         bus.target_valid = 1'b0;
      end
      bus.target = tgt;
      bus.target_valid = 1'b1;
      tick();
      bus.target_valid = 1'b0;
      bus.target = 8'($urandom_range(0, 255));
      chk("armed_led", 32'(bus.led), 32'(tgt));
      chk("armed_req", 32'(bus.target_req), 0);
      if (kind == 3) begin
         for (int i = 1; i <= teff; i++) begin
            tick();
            if (i < teff) chk("tmo_early", 32'({bus.hit, bus.miss}), 0);
         end
         got_hit = 1'b0;
      end else begin
         for (int i = 0; i < dd; i++) begin
            tick();
            chk("armed_quiet", 32'({bus.hit, bus.miss}), 0);
         end
         mask = (kind == 0) ? tgt : (kind == 1) ? (8'h01 << j) : (tgt | (8'h01 << j));
         bus.switch ^= mask;
         tick();
         got_hit = (kind == 0);
      end
      exp_round++;
      if (got_hit) begin
         if (exp_score < SMAX) exp_score++;
         tok_base = cyc;
      end else if (exp_miss < SMAX) begin
         exp_miss++;
      end
      chk("res_hit",  32'(bus.hit),  32'(got_hit));
      chk("res_miss", 32'(bus.miss), 32'(!got_hit));
      chk("res_led",  32'(bus.led), 0);
      chk("res_done", 32'(bus.done), 32'(exp_round == ROUNDS));
      chk("res_req",  32'(bus.target_req), 32'(exp_round != ROUNDS));
      chk_counters("res");
   endtask

   initial begin
      logic [7:0] bad;
      bus.start = 1'b0;
      bus.switch = 8'h00;
      bus.target = 8'h00;
      bus.target_valid = 1'b0;
      bus.timeout_cycles = 16'd10;
      exp_score = 0;
      exp_miss = 0;
      exp_round = 0;
      tok_base = 0;

      // Reset state
      tick();
      tick();
      chk("rst_busy", 32'(bus.busy), 0);
      chk("rst_done", 32'(bus.done), 0);
      chk("rst_req",  32'(bus.target_req), 0);
      chk("rst_led",  32'(bus.led), 0);
      chk("rst_token", 32'(bus.token), 0);
      chk("rst_pulse", 32'({bus.hit, bus.miss}), 0);
      rst = 1'b0;
      tok_base = cyc;
      tick();
      chk("idle_busy", 32'(bus.busy), 0);
      chk_counters("idle");

      // Directed: hit, wrong switch, 10-cycle timeout, zero timeout
      start_game();
      do_round(2, 0, 0, 20, 8'h00, 1'b0);
      do_round(2, 1, 1, 20, 8'h00, 1'b0);
      do_round(5, 3, 0, 10, 8'h00, 1'b0);
      do_round(3, 3, 0, 0,  8'h00, 1'b0);
      end_game();

      // Directed: flip on the timeout edge, multi-bit flip, bad targets, start while busy
      start_game();
      do_round(2, 0, 4, 5, 8'h00, 1'b0);
      do_round(2, 2, 2, 8, 8'h00, 1'b0);
      do_round(0, 0, 0, 6, 8'h06, 1'b1);
      do_round(7, 1, 0, 3, 8'h00, 1'b1);
      end_game();

      // Saturation of score and misses
      start_game();
      for (int r = 0; r < ROUNDS; r++) do_round(r, 0, r, 7, 8'h00, 1'b0);
      end_game();
      start_game();
      for (int r = 0; r < ROUNDS; r++) do_round(r + 3, 1 + (r % 3), 1, 4, 8'h00, 1'b0);
      end_game();

      // Randomized games
      for (int g = 0; g < 8; g++) begin
         start_game();
         for (int r = 0; r < ROUNDS; r++) begin
            bad = 8'($urandom_range(0, 255));
            if ($countones(bad) < 2) bad = 8'h03;
            if ($urandom_range(0, 3) != 0) bad = 8'h00;
            do_round(int'($urandom_range(0, 7)), int'($urandom_range(0, 3)),
                     int'($urandom_range(0, 12)), int'($urandom_range(0, 12)),
                     bad, 1'($urandom_range(0, 1)));
         end
         end_game();
      end

      // Reset in the middle of an armed round
      start_game();
      do_round(1, 0, 0, 9, 8'h00, 1'b0);
      bus.target = 8'h10;
      bus.target_valid = 1'b1;
      tick();
      bus.target_valid = 1'b0;
      chk("pre_rst_led", 32'(bus.led), 32'h10);
      tick();
      rst = 1'b1;
      #1;
      chk("mid_rst_busy",  32'(bus.busy), 0);
      chk("mid_rst_led",   32'(bus.led), 0);
      chk("mid_rst_score", 32'(bus.score), 0);
      chk("mid_rst_round", 32'(bus.round_cnt), 0);
      chk("mid_rst_token", 32'(bus.token), 0);
      tick();
      rst = 1'b0;
      tok_base = cyc;
      exp_score = 0;
      exp_miss = 0;
      exp_round = 0;
      tick();
      chk("post_rst_busy", 32'(bus.busy), 0);
      chk("post_rst_done", 32'(bus.done), 0);
      chk("post_rst_req",  32'(bus.target_req), 0);
      chk_counters("post_rst");
      start_game();
      do_round(6, 0, 2, 5, 8'h00, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule
